// File: rtl/axum_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus host port among NrHosts hosts.
// Granted host indices are queued in issue order so each response returns to its issuer.
module axum_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*4-1:0]              host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              bus_req_o,
    output logic [AddressWidth-1:0]           bus_addr_o,
    output logic                              bus_we_o,
    output logic [3:0]                        bus_be_o,
    output logic [DataWidth-1:0]              bus_wdata_o,
    input  logic                              bus_gnt_i,
    input  logic                              bus_rvalid_i,
    input  logic [DataWidth-1:0]              bus_rdata_i,
    input  logic                              bus_err_i,
    output logic                              spurious_o
);

    localparam int IdxW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int CandW = IdxW + 1;
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);

    localparam logic [IdxW-1:0]  LastHost  = IdxW'(NrHosts - 1);
    localparam logic [PtrW-1:0]  LastSlot  = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0]  FullCount = CntW'(MaxOutstanding);
    localparam logic [CandW-1:0] HostCount = CandW'(NrHosts);

    logic [IdxW-1:0]  rr_ptr;
    logic [IdxW-1:0]  lock_idx;
    logic             lock_vld;
    logic [CntW-1:0]  count;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic             spurious;
    logic [IdxW-1:0]  fifo_q [MaxOutstanding];

    logic [IdxW-1:0]  sel_idx;
    logic             sel_found;
    logic [CandW-1:0] cand;
    logic [IdxW-1:0]  head_idx;
    logic             can_issue;
    logic             hs;
    logic             pop;

    // A locked host keeps the slot until its handshake; otherwise search from rr_ptr.
    always_comb begin
        sel_idx   = rr_ptr;
        sel_found = 1'b0;
        cand      = '0;
        if (lock_vld) begin
            sel_idx   = lock_idx;
            sel_found = host_req_i[lock_idx];
        end else begin
            for (int i = 0; i < NrHosts; i++) begin
                cand = {1'b0, rr_ptr} + CandW'(i);
                if (cand >= HostCount) begin
                    cand = cand - HostCount;
                end
                if (!sel_found && host_req_i[cand[IdxW-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand[IdxW-1:0];
                end
            end
        end
    end

    // Full FIFO blocks new requests even when a response pops in the same cycle.
    assign can_issue = (count < FullCount);
    assign bus_req_o = ~rst_i & sel_found & can_issue;
    assign hs        = bus_req_o & bus_gnt_i;
    assign head_idx  = fifo_q[rd_ptr];
    assign pop       = ~rst_i & bus_rvalid_i & (count != '0);

    always_comb begin
        bus_addr_o  = '0;
        bus_we_o    = 1'b0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        host_gnt_o  = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (sel_idx == IdxW'(h)) begin
                bus_addr_o    = host_addr_i[h*AddressWidth +: AddressWidth];
                bus_we_o      = host_we_i[h];
                bus_be_o      = host_be_i[h*4 +: 4];
                bus_wdata_o   = host_wdata_i[h*DataWidth +: DataWidth];
                host_gnt_o[h] = hs;
            end
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (pop && (head_idx == IdxW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = bus_err_i;
            end
        end
    end

    assign host_rdata_o = {NrHosts{bus_rdata_i}};
    assign spurious_o   = spurious & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            spurious <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr   <= (sel_idx == LastHost) ? '0 : sel_idx + 1'b1;
                lock_vld <= 1'b0;
            end else if (bus_req_o) begin
                lock_vld <= 1'b1;
                lock_idx <= sel_idx;
            end else if (lock_vld && !host_req_i[lock_idx]) begin
                lock_vld <= 1'b0;
            end

            if (hs) begin
                wr_ptr <= (wr_ptr == LastSlot) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastSlot) ? '0 : rd_ptr + 1'b1;
            end

            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (bus_rvalid_i && (count == '0)) begin
                spurious <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_ptr] <= sel_idx;
        end
    end

endmodule

// File: tb/tb_axum_host_arbiter.sv
// Directed bench for axum_host_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares them whenever a host rvalid appears.
module tb_axum_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  host_req;
    logic [1:0]  host_gnt_o;
    logic [63:0] host_addr;
    logic [1:0]  host_we;
    logic [7:0]  host_be;
    logic [63:0] host_wdata;
    logic [1:0]  host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic [1:0]  host_err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        spurious_o;

    typedef struct packed {
        logic        host;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    axum_host_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .host_req_i   (host_req),
        .host_gnt_o   (host_gnt_o),
        .host_addr_i  (host_addr),
        .host_we_i    (host_we),
        .host_be_i    (host_be),
        .host_wdata_i (host_wdata),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .host_err_o   (host_err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_we_o     (bus_we_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .bus_err_i    (bus_err),
        .spurious_o   (spurious_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic er);
        host_req   = req;
        bus_gnt    = gnt;
        bus_rvalid = rv;
        bus_rdata  = rd;
        bus_err    = er;
    endtask

    task automatic expect_rsp(input logic hh, input logic [31:0] d, input logic er);
        exp_q.push_back('{host: hh, data: d, err: er});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        int   h;
        if (!rst && (host_rvalid_o != 2'b00)) begin
            chk("rvalid_onehot", $countones(host_rvalid_o), 1);
            chk("err_owner", host_err_o & ~host_rvalid_o, 0);
            h = host_rvalid_o[1] ? 1 : 0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual host=%0d required none", h);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_host", 64'(h), 64'(e.host));
                chk("rsp_data", host_rdata_o[h*32 +: 32], e.data);
                chk("rsp_err", host_err_o[h], e.err);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        host_addr  = {32'h0020_0000, 32'h0010_0000};
        host_we    = 2'b10;
        host_be    = {4'hC, 4'hF};
        host_wdata = {32'h2222_2222, 32'h1111_1111};

        // Reset: outputs gated, rdata still broadcast
        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
        #2;
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_gnt", host_gnt_o, 0);
        chk("rst_rvalid", host_rvalid_o, 0);
        chk("rst_err", host_err_o, 0);
        chk("rst_spurious", spurious_o, 0);
        chk("rst_rdata_pass", host_rdata_o, {2{32'hCAFE_F00D}});
        cyc();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("post_rst_spurious", spurious_o, 0);

        // Single host transaction
        cyc();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t1_bus_req", bus_req_o, 1);
        chk("t1_addr", bus_addr_o, 32'h0010_0000);
        chk("t1_gnt", host_gnt_o, 2'b01);
        chk("t1_wdata", bus_wdata_o, 32'h1111_1111);
        chk("t1_we", bus_we_o, 0);
        chk("t1_be", bus_be_o, 4'hF);
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("t1_rvalid", host_rvalid_o, 2'b01);
        cyc();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // Fairness: rr_ptr is 1 after host0's grant, so grants go 1,0,1,0,1
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive(2'b11, 1'b1, (i > 0), 32'hA000_0000 + i, 1'b0);
            if (i > 0) expect_rsp((i % 2) == 1, 32'hA000_0000 + i, 1'b0);
            #1;
            chk("fair_bus_req", bus_req_o, 1);
            chk("fair_gnt", host_gnt_o, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'hA000_0005, 1'b0);
        expect_rsp(1'b1, 32'hA000_0005, 1'b0);
        #1;
        chk("fair_idle_req", bus_req_o, 0);

        // Lock: host1 waits for grant while host0 also requests
        cyc();
        drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lock0_req", bus_req_o, 1);
        chk("lock0_addr", bus_addr_o, 32'h0020_0000);
        chk("lock0_we", bus_we_o, 1);
        chk("lock0_be", bus_be_o, 4'hC);
        chk("lock0_gnt", host_gnt_o, 2'b00);
        for (int i = 1; i < 3; i++) begin
            cyc();
            drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            chk("lock_hold_addr", bus_addr_o, 32'h0020_0000);
            chk("lock_hold_gnt", host_gnt_o, 2'b00);
        end
        cyc();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lock3_gnt", host_gnt_o, 2'b10);
        chk("lock3_addr", bus_addr_o, 32'h0020_0000);
        cyc();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lock4_gnt", host_gnt_o, 2'b01);
        chk("lock4_addr", bus_addr_o, 32'h0010_0000);

        // Backpressure: FIFO holds host1, host0
        for (int i = 0; i < 2; i++) begin
            cyc();
            drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            chk("bp_full_req", bus_req_o, 0);
            chk("bp_full_gnt", host_gnt_o, 2'b00);
        end
        cyc();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_00E1, 1'b1);
        expect_rsp(1'b1, 32'h0000_00E1, 1'b1);
        #1;
        chk("bp_err", host_err_o, 2'b10);
        chk("bp_rvalid", host_rvalid_o, 2'b10);
        chk("bp_no_bypass", bus_req_o, 0);
        cyc();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("bp_resume_req", bus_req_o, 1);
        chk("bp_resume_gnt", host_gnt_o, 2'b10);
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_00B0, 1'b0);
        expect_rsp(1'b0, 32'h0000_00B0, 1'b0);
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_00B1, 1'b0);
        expect_rsp(1'b1, 32'h0000_00B1, 1'b0);

        // Ordering with simultaneous push and pop
        cyc();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("ord0_gnt", host_gnt_o, 2'b01);
        cyc();
        drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("ord1_gnt", host_gnt_o, 2'b10);
        cyc();
        drive(2'b01, 1'b1, 1'b1, 32'h0000_00C0, 1'b0);
        expect_rsp(1'b0, 32'h0000_00C0, 1'b0);
        #1;
        chk("ord2_full_req", bus_req_o, 0);
        chk("ord2_rvalid", host_rvalid_o, 2'b01);
        cyc();
        drive(2'b01, 1'b1, 1'b1, 32'h0000_00C1, 1'b0);
        expect_rsp(1'b1, 32'h0000_00C1, 1'b0);
        #1;
        chk("ord3_gnt", host_gnt_o, 2'b01);
        chk("ord3_rvalid", host_rvalid_o, 2'b10);
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_00C2, 1'b0);
        expect_rsp(1'b0, 32'h0000_00C2, 1'b0);
        #1;
        chk("ord4_rvalid", host_rvalid_o, 2'b01);

        // Spurious response and reset with one request outstanding
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0055, 1'b0);
        #1;
        chk("spur_no_rvalid", host_rvalid_o, 2'b00);
        chk("spur_not_yet", spurious_o, 0);
        cyc();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("spur_set", spurious_o, 1);
        cyc();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("spur_gnt", host_gnt_o, 2'b01);
        chk("spur_sticky", spurious_o, 1);
        cyc();
        drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_spurious", spurious_o, 0);
        chk("mid_rst_req", bus_req_o, 0);
        cyc();
        rst = 1'b0;
        drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("after_rst_req", bus_req_o, 1);
        chk("after_rst_rr", bus_addr_o, 32'h0010_0000);
        chk("after_rst_spurious", spurious_o, 0);
        cyc();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0066, 1'b0);
        #1;
        chk("late_rsp_dropped", host_rvalid_o, 2'b00);
        cyc();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("late_rsp_spurious", spurious_o, 1);

        // Locked host withdrawing its request releases the lock
        cyc();
        drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("drop_lock_addr", bus_addr_o, 32'h0020_0000);
        cyc();
        drive(2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("drop_unlock_gnt", host_gnt_o, 2'b01);
        chk("drop_unlock_addr", bus_addr_o, 32'h0010_0000);

        cyc();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
